// File: rtl/lsu_ctrl.sv
// Load/store unit controller: decodes one execute-stage access at a time and
// drives a single-outstanding req/gnt/rvalid data-memory port.
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic [1:0]  rsp_err_cause,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [15:0] tcnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  be_q;
  logic [4:0]  rd_q;
  logic        err_q;
  logic [1:0]  cause_q;

  logic        f3_legal;
  logic        misaligned;
  logic [3:0]  be_dec;
  logic [31:0] wdata_dec;
  logic [1:0]  cause_dec;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic        timeout_hit;

  // Request decode: funct3[1:0] is the access size, funct3[2] the unsigned flag.
  always_comb begin
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    be_dec     = 4'b0000;
    wdata_dec  = 32'h0;
    if (req_store)
      f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else
      f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                 (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    case (req_funct3[1:0])
      2'b00: begin
        be_dec    = 4'b0001 << req_addr[1:0];
        wdata_dec = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr[0];
        be_dec     = 4'b0011 << req_addr[1:0];
        wdata_dec  = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = |req_addr[1:0];
        be_dec     = 4'b1111;
        wdata_dec  = req_wdata;
      end
      default: ;
    endcase
    if (!f3_legal)
      cause_dec = 2'd2;
    else if (misaligned)
      cause_dec = 2'd1;
    else
      cause_dec = 2'd0;
  end

  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == TMAX);

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = (cause_dec == 2'd0) ? REQ : RESP;
      REQ: begin
        if (mem_gnt)
          state_next = WAIT;
        else if (timeout_hit)
          state_next = RESP;
      end
      WAIT: if (mem_rvalid || timeout_hit) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers; the timeout counter restarts on entry to REQ and WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      tcnt       <= 16'h0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      be_q       <= 4'b0000;
      rd_q       <= 5'd0;
      err_q      <= 1'b0;
      cause_q    <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_store_q <= req_store;
            funct3_q   <= req_funct3;
            off_q      <= req_addr[1:0];
            addr_q     <= {req_addr[31:2], 2'b00};
            wdata_q    <= wdata_dec;
            be_q       <= be_dec;
            rd_q       <= req_rd;
            rdata_q    <= 32'h0;
            err_q      <= (cause_dec != 2'd0);
            cause_q    <= cause_dec;
            tcnt       <= 16'h0;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            tcnt <= 16'h0;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            cause_q <= 2'd3;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata_q <= is_store_q ? 32'h0 : load_ext;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            cause_q <= 2'd3;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs are masked by rst so they are low during the reset cycle itself.
  assign req_ready     = (state == IDLE) && !rst;
  assign mem_req       = (state == REQ) && !rst;
  assign rsp_valid     = (state == RESP) && !rst;
  assign mem_we        = is_store_q;
  assign mem_addr      = addr_q;
  assign mem_be        = be_q;
  assign mem_wdata     = wdata_q;
  assign rsp_rd        = rd_q;
  assign rsp_rdata     = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err       = rsp_valid & err_q;
  assign rsp_err_cause = rsp_valid ? cause_q : 2'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl with a short timeout so the abort path is quick to reach.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic [1:0]  rsp_err_cause;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
    .rsp_err(rsp_err), .rsp_err_cause(rsp_err_cause),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents a request for one edge; returns in cycle 1 after acceptance.
  task automatic applyStimulus(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd);
    req_store  = store;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
  endtask

  // Grants in the current cycle, responds in the next; returns in the RESP cycle.
  task automatic grantAndRespond(input logic [31:0] rdata);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    #1;
    checkOutput("ready_in_reset_pre", 32'(req_ready), 32'h0);
    tick();
    tick();
    checkOutput("ready_in_reset", 32'(req_ready), 32'h0);
    checkOutput("memreq_reset", 32'(mem_req), 32'h0);
    checkOutput("rspvalid_reset", 32'(rsp_valid), 32'h0);
    checkOutput("memaddr_reset", mem_addr, 32'h0);
    checkOutput("membe_reset", 32'(mem_be), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", 32'(req_ready), 32'h1);

    // LB at 0x103: top byte 0x80 sign-extends
    applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 5'd5);
    checkOutput("lb_memreq", 32'(mem_req), 32'h1);
    checkOutput("lb_addr", mem_addr, 32'h100);
    checkOutput("lb_be", 32'(mem_be), 32'h8);
    checkOutput("lb_we", 32'(mem_we), 32'h0);
    checkOutput("lb_ready_busy", 32'(req_ready), 32'h0);
    grantAndRespond(32'h80FF1234);
    checkOutput("lb_rspvalid", 32'(rsp_valid), 32'h1);
    checkOutput("lb_rdata", rsp_rdata, 32'hFFFFFF80);
    checkOutput("lb_err", 32'(rsp_err), 32'h0);
    checkOutput("lb_rd", 32'(rsp_rd), 32'd5);
    tick();
    checkOutput("lb_rspvalid_drop", 32'(rsp_valid), 32'h0);
    checkOutput("lb_rdata_zero", rsp_rdata, 32'h0);
    checkOutput("lb_ready_back", 32'(req_ready), 32'h1);

    applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 5'd6);
    grantAndRespond(32'h80FF1234);
    checkOutput("lbu_rdata", rsp_rdata, 32'h00000080);
    tick();

    // SH at 0x202: upper halfword lanes, data replicated
    applyStimulus(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd7);
    checkOutput("sh_addr", mem_addr, 32'h200);
    checkOutput("sh_be", 32'(mem_be), 32'hC);
    checkOutput("sh_wdata", mem_wdata, 32'hABCDABCD);
    checkOutput("sh_we", 32'(mem_we), 32'h1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checkOutput("sh_memreq_drop", 32'(mem_req), 32'h0);
    checkOutput("sh_rspvalid_early", 32'(rsp_valid), 32'h0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("sh_rspvalid_c3", 32'(rsp_valid), 32'h1);
    checkOutput("sh_rdata", rsp_rdata, 32'h0);
    checkOutput("sh_err", 32'(rsp_err), 32'h0);
    tick();

    // Error paths: respond in cycle 1 without a memory request
    applyStimulus(1'b0, 3'b010, 32'h101, 32'h0, 5'd1);
    checkOutput("lw_mis_memreq", 32'(mem_req), 32'h0);
    checkOutput("lw_mis_rspvalid", 32'(rsp_valid), 32'h1);
    checkOutput("lw_mis_err", 32'(rsp_err), 32'h1);
    checkOutput("lw_mis_cause", 32'(rsp_err_cause), 32'd1);
    checkOutput("lw_mis_rdata", rsp_rdata, 32'h0);
    tick();
    checkOutput("lw_mis_idle_memreq", 32'(mem_req), 32'h0);
    checkOutput("lw_mis_idle_cause", 32'(rsp_err_cause), 32'd0);

    applyStimulus(1'b0, 3'b011, 32'h101, 32'h0, 5'd2);
    checkOutput("ill_load_cause", 32'(rsp_err_cause), 32'd2);
    checkOutput("ill_load_memreq", 32'(mem_req), 32'h0);
    tick();

    applyStimulus(1'b1, 3'b100, 32'h40, 32'h0, 5'd2);
    checkOutput("ill_store_cause", 32'(rsp_err_cause), 32'd2);
    tick();

    applyStimulus(1'b1, 3'b001, 32'h41, 32'h0, 5'd2);
    checkOutput("sh_mis_cause", 32'(rsp_err_cause), 32'd1);
    tick();

    // SW at 0x40 with grant withheld for three cycles
    applyStimulus(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 5'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("sw_stall_memreq%0d", i), 32'(mem_req), 32'h1);
      checkOutput($sformatf("sw_stall_addr%0d", i), mem_addr, 32'h40);
      checkOutput($sformatf("sw_stall_be%0d", i), 32'(mem_be), 32'hF);
      checkOutput($sformatf("sw_stall_wdata%0d", i), mem_wdata, 32'hCAFEF00D);
      checkOutput($sformatf("sw_stall_we%0d", i), 32'(mem_we), 32'h1);
      checkOutput($sformatf("sw_stall_ready%0d", i), 32'(req_ready), 32'h0);
      if (i == 3) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    checkOutput("sw_wait_memreq", 32'(mem_req), 32'h0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("sw_rspvalid", 32'(rsp_valid), 32'h1);
    checkOutput("sw_err", 32'(rsp_err), 32'h0);
    tick();

    // Grant timeout: mem_req high for exactly 8 cycles
    applyStimulus(1'b0, 3'b010, 32'h80, 32'h0, 5'd8);
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    checkOutput("gnt_to_cycles", 32'(cnt), 32'd8);
    checkOutput("gnt_to_rspvalid", 32'(rsp_valid), 32'h1);
    checkOutput("gnt_to_err", 32'(rsp_err), 32'h1);
    checkOutput("gnt_to_cause", 32'(rsp_err_cause), 32'd3);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    tick();
    checkOutput("stray_rvalid_rsp0", 32'(rsp_valid), 32'h0);
    tick();
    checkOutput("stray_rvalid_rsp1", 32'(rsp_valid), 32'h0);
    checkOutput("stray_rvalid_ready", 32'(req_ready), 32'h1);
    mem_rvalid = 1'b0;

    // Response timeout: granted, then rvalid never arrives
    applyStimulus(1'b0, 3'b010, 32'h84, 32'h0, 5'd9);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    cnt = 0;
    while (rsp_valid !== 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    checkOutput("rsp_to_cycles", 32'(cnt), 32'd8);
    checkOutput("rsp_to_cause", 32'(rsp_err_cause), 32'd3);
    tick();

    // Reset while waiting for the response
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 5'd3);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("rst_wait_memreq", 32'(mem_req), 32'h0);
    checkOutput("rst_wait_rspvalid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_wait_addr", mem_addr, 32'h0);
    checkOutput("rst_wait_rd", 32'(rsp_rd), 32'h0);
    checkOutput("rst_wait_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("rst_wait_ready_after", 32'(req_ready), 32'h1);

    applyStimulus(1'b0, 3'b101, 32'h2, 32'h0, 5'd10);
    checkOutput("lhu_be", 32'(mem_be), 32'hC);
    checkOutput("lhu_addr", mem_addr, 32'h0);
    grantAndRespond(32'hBEEF0000);
    checkOutput("lhu_rdata", rsp_rdata, 32'h0000BEEF);
    checkOutput("lhu_rd", 32'(rsp_rd), 32'd10);
    tick();

    applyStimulus(1'b0, 3'b001, 32'h2, 32'h0, 5'd11);
    grantAndRespond(32'hBEEF0000);
    checkOutput("lh_rdata", rsp_rdata, 32'hFFFFBEEF);
    tick();

    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd12);
    checkOutput("lb0_be", 32'(mem_be), 32'h1);
    grantAndRespond(32'h000000F0);
    checkOutput("lb0_rdata", rsp_rdata, 32'hFFFFFFF0);
    tick();

    applyStimulus(1'b1, 3'b000, 32'h1, 32'h000000A5, 5'd0);
    checkOutput("sb_be", 32'(mem_be), 32'h2);
    checkOutput("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    grantAndRespond(32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller for the rv32i core. Accepts one load or store at a time from the execute stage and drives a single-outstanding request/grant/response data-memory port. Generates word-aligned addresses, byte enables and replicated store data, and returns sign- or zero-extended load data. Detects misaligned and illegal-funct3 accesses, and bus timeouts, without touching memory.

## Interface
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for grant or for response; range 0..65535; 0 disables the timeout
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  execute-stage request valid
- req_ready  out  1  controller idle and able to accept a request
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW encodings)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; bits above the access size are ignored
- req_rd  in  5  destination register, echoed on the response
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_rd  out  5  echoed req_rd
- rsp_err  out  1  access failed
- rsp_err_cause  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 bus timeout
- mem_req  out  1  memory request
- mem_gnt  in  1  memory grant
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_be  out  4  byte enables (loads and stores)
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  32  memory read data

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. req_ready = (state == IDLE).
- IDLE: on req_valid, the request is decoded and all mem_* fields and rd are registered.
  - Legal and aligned -> REQ.
  - Otherwise -> RESP with the error.
  - Illegal funct3 takes priority over misaligned.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
- Alignment: halfword requires addr[0] = 0; word requires addr[1:0] = 0.
- Byte enables, with off = addr[1:0]:
  - byte: mem_be = 4'b0001 << off.
  - half: mem_be = 4'b0011 << off.
  - word: mem_be = 4'b1111.
- Store data: SB = {4{wdata[7:0]}}, SH = {2{wdata[15:0]}}, SW = wdata.
- REQ: mem_req = 1; mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_gnt. On mem_gnt -> WAIT (mem_req drops next cycle).
- WAIT: on mem_rvalid -> RESP. For loads, mem_rdata is captured and extracted:
  - LB/LBU: mem_rdata[8*off +: 8], sign- or zero-extended.
  - LH/LHU: mem_rdata[8*off +: 16], sign- or zero-extended.
  - LW: the full word.
- mem_rvalid in REQ or IDLE is ignored. This covers stray responses after a timeout or reset.
- Timeout counter: 16 bits, cleared on entry to REQ and to WAIT, increments each cycle in that state. If it equals TIMEOUT_CYCLES-1 and no gnt/rvalid occurs that cycle -> RESP with cause 3, and mem_req drops.
- RESP: rsp_valid = 1 for exactly one cycle, then -> IDLE. rsp_rdata/rsp_rd/rsp_err/rsp_err_cause are valid only while rsp_valid = 1 and are 0 otherwise (rsp_rd is held).

## Timing
- Reset: state = IDLE and every output = 0. This includes req_ready during the reset cycle; req_ready = 1 from the first cycle after rst deasserts.
- Reset mid-transaction aborts immediately: mem_req = 0 and no rsp_valid at the next edge.
- Accept at edge 0:
  - mem_req is high in cycle 1.
  - Earliest grant is cycle 1 -> WAIT in cycle 2.
  - Earliest rvalid is cycle 2 -> rsp_valid in cycle 3.
  - Minimum latency is 3 cycles; rvalid in the same cycle as gnt is not supported.
- Error path: accept at edge 0 -> rsp_valid in cycle 1; no mem_req at any point.
- Throughput: next request is accepted in the cycle after RESP, so at best one access per 4 cycles.
- With the timeout enabled, mem_req stays high for exactly TIMEOUT_CYCLES cycles without a grant before the abort.

## Test plan
- LB, addr 0x103, mem_rdata 0x80FF1234 -> mem_addr 0x100, mem_be 1000, mem_we 0; rsp_rdata 0xFFFFFF80, rsp_err 0. Same access as LBU -> 0x00000080.
- SH, addr 0x202, wdata 0x1234ABCD -> mem_addr 0x200, mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1; rsp_rdata 0, rsp_valid 3 cycles after acceptance when gnt and rvalid come at the earliest cycles.
- LW at 0x101 -> no mem_req, rsp_valid 1 cycle after acceptance with cause 1. Load with funct3 011 at 0x101 -> cause 2.
- Grant stalled 3 cycles on SW at 0x40 -> mem_req and all mem_* fields constant for 4 cycles; req_ready 0 throughout.
- TIMEOUT_CYCLES = 8, mem_gnt held 0 -> mem_req high for exactly 8 cycles, then rsp_valid with cause 3. A later stray mem_rvalid in IDLE produces no response.
- rst asserted while in WAIT -> next cycle all outputs 0 and state IDLE. A following LHU at 0x2, mem_rdata 0xBEEF0000, returns 0x0000BEEF.
